// File: rtl/dcache_arb.sv
// dcache_arb: round-robin arbiter that lets NUM_REQ threads share one data
// cache port. It handles one access at a time: segment range check, cache
// strobe, miss refill with timeout, replay after refill, and a one-cycle
// response to the thread that was granted.
module dcache_arb #(
  parameter int NUM_REQ      = 4,
  parameter int FILL_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*20-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_fault,
  output logic [19:0]             c_addr,
  output logic [31:0]             c_wr_data,
  output logic                    c_wr_en,
  output logic                    c_rd_en,
  input  logic [31:0]             c_rd_data,
  input  logic                    c_miss,
  output logic                    fill_req,
  output logic [19:0]             fill_addr,
  input  logic                    fill_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(FILL_TIMEOUT + 1);

  // Legal data segment; anything outside faults without touching the cache.
  localparam logic [19:0] SEG_LO = 20'h10200;
  localparam logic [19:0] SEG_HI = 20'h102FF;

  // Value of the FILL counter during the last FILL cycle before timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    FILL  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic               cap_fault;
  logic [CNT_W-1:0]   fill_cnt;

  // Captured request payload (data path, not reset).
  logic               cap_we;
  logic [19:0]        cap_addr;
  logic [31:0]        cap_wdata;

  // Round-robin selection results.
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [19:0]        pick_addr;
  logic               grant_now;

  function automatic logic in_segment(input logic [19:0] a);
    return (a >= SEG_LO) && (a <= SEG_HI);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Pick the first valid requester at or after rr_ptr; scanning from the far
  // end backwards lets the nearest candidate overwrite the others.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_addr = req_addr[int'(pick_idx)*20 +: 20];

  // A grant is made only from IDLE, and not in the cycle req_ready is
  // already showing the previous grant.
  assign grant_now = (state == IDLE) && (req_ready == '0) && pick_found;

  // Latch the granted thread's access; held until the next grant.
  always_ff @(posedge clk) begin
    if (grant_now) begin
      cap_we    <= req_we[pick_idx];
      cap_addr  <= pick_addr;
      cap_wdata <= req_wdata[int'(pick_idx)*32 +: 32];
    end
  end

  // Access sequencer: grant, range check, issue, hit/miss check, refill with
  // timeout, and response. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cap_fault <= 1'b0;
      fill_cnt  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      c_addr    <= '0;
      c_wr_data <= '0;
      c_wr_en   <= 1'b0;
      c_rd_en   <= 1'b0;
      fill_req  <= 1'b0;
      fill_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready != '0) begin
            // Grant cycle: the payload is now captured, dispatch it.
            req_ready <= '0;
            if (cap_fault) begin
              state     <= RESP;
              rsp_valid <= onehot(gnt_idx);
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ISSUE;
              c_addr    <= cap_addr;
              c_wr_data <= cap_wdata;
              c_wr_en   <= cap_we;
              c_rd_en   <= ~cap_we;
            end
          end else if (pick_found) begin
            req_ready <= onehot(pick_idx);
            gnt_idx   <= pick_idx;
            rr_ptr    <= ptr_after(pick_idx);
            cap_fault <= ~in_segment(pick_addr);
          end
        end

        ISSUE: begin
          // Strobe lasts exactly one cycle; miss/data come back in CHECK.
          state     <= CHECK;
          c_addr    <= '0;
          c_wr_data <= '0;
          c_wr_en   <= 1'b0;
          c_rd_en   <= 1'b0;
        end

        CHECK: begin
          if (!c_miss) begin
            state     <= RESP;
            rsp_valid <= onehot(gnt_idx);
            rsp_fault <= 1'b0;
            rsp_rdata <= cap_we ? 32'h0 : c_rd_data;
          end else begin
            state     <= FILL;
            fill_req  <= 1'b1;
            fill_addr <= cap_addr;
            fill_cnt  <= '0;
          end
        end

        FILL: begin
          if (fill_done) begin
            // Line is now resident: replay the same access.
            state     <= ISSUE;
            fill_req  <= 1'b0;
            fill_addr <= '0;
            c_addr    <= cap_addr;
            c_wr_data <= cap_wdata;
            c_wr_en   <= cap_we;
            c_rd_en   <= ~cap_we;
          end else if (fill_cnt == CNT_LAST) begin
            state     <= RESP;
            fill_req  <= 1'b0;
            fill_addr <= '0;
            rsp_valid <= onehot(gnt_idx);
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= '0;
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_arb.md
DCACHE_ARB -- requirements
Module: dcache_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of thread requesters, legal range 2..8.
REQ-002 Parameter FILL_TIMEOUT, default 64: maximum number of FILL cycles before an access is aborted.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-thread access request.
REQ-006 req_we  input  NUM_REQ  per-thread write flag: 1 = write, 0 = read.
REQ-007 req_addr  input  NUM_REQ*20  per-thread address; thread i occupies bits [20i+19:20i].
REQ-008 req_wdata  input  NUM_REQ*32  per-thread write data; thread i occupies bits [32i+31:32i].
REQ-009 req_ready  output  NUM_REQ  one-hot grant pulse; the request is captured on this cycle.
REQ-010 rsp_valid  output  NUM_REQ  one-hot response pulse, one cycle long.
REQ-011 rsp_rdata  output  32  read data; valid when any rsp_valid bit is set.
REQ-012 rsp_fault  output  1  qualifies the response: 1 = segmentation fault or timeout.
REQ-013 c_addr  output  20  cache address.
REQ-014 c_wr_data  output  32  cache write data.
REQ-015 c_wr_en, c_rd_en  output  1 each  cache strobes.
REQ-016 c_rd_data  input  32  cache read data; valid one cycle after c_rd_en.
REQ-017 c_miss  input  1  cache miss flag; valid one cycle after the strobe.
REQ-018 fill_req  output  1  refill request to the memory side.
REQ-019 fill_addr  output  20  address to refill.
REQ-020 fill_done  input  1  one-cycle refill completion pulse.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, CHECK, FILL and RESP, with exactly one access in flight at a time.
REQ-022 IDLE: when any req_valid bit is set, grant the first requester at or after rr_ptr (round-robin), assert its req_ready for one cycle, and capture we, addr and wdata.
REQ-023 After a grant, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; rr_ptr SHALL NOT change without a grant.
REQ-024 Range check at grant: a captured address outside 0x10200..0x102FF (inclusive) SHALL go directly to RESP with rsp_fault=1.
REQ-025 A faulting access SHALL assert no cache strobe and no fill_req.
REQ-026 A grant with an in-range address SHALL go to ISSUE.
REQ-027 ISSUE: for one cycle, drive c_addr = captured addr, assert c_rd_en (read) or c_wr_en (write), and drive c_wr_data = captured wdata.
REQ-028 ISSUE SHALL always be followed by CHECK.
REQ-029 CHECK: if c_miss=0, latch c_rd_data (reads only) and go to RESP.
REQ-030 CHECK: if c_miss=1, go to FILL.
REQ-031 FILL: hold fill_req=1 and fill_addr = captured addr, and count FILL cycles.
REQ-032 fill_done in FILL SHALL drop fill_req the next cycle and replay the access (go to ISSUE); there is no limit on the number of replays.
REQ-033 If the FILL count reaches FILL_TIMEOUT without fill_done, the FSM SHALL go to RESP with rsp_fault=1 and drop fill_req.
REQ-034 A fill_done arriving in any state other than FILL SHALL be ignored.
REQ-035 RESP: assert rsp_valid for the granted thread only, for exactly one cycle, then return to IDLE.
REQ-036 rsp_rdata SHALL be the latched data for a read, and SHALL be 0 for a write or a fault.
REQ-037 A thread SHALL NOT be granted again before its previous response has been issued.
REQ-038 Latency, measured from the grant cycle T: a hit (read or write) gives rsp_valid at T+3; a segmentation fault gives rsp_valid at T+1.
REQ-039 A new grant SHALL be possible no earlier than the cycle after RESP.
REQ-040 req_valid deasserted while not granted SHALL be allowed; requests are not latched before grant.
REQ-041 The timeout counter SHALL be $clog2(FILL_TIMEOUT+1) bits wide, and SHALL clear on entry to FILL.

Reset
REQ-042 Reset assertion SHALL immediately force state IDLE and rr_ptr=0, and drive every output to 0: req_ready, rsp_valid, rsp_rdata, rsp_fault, c_addr, c_wr_data, c_wr_en, c_rd_en, fill_req and fill_addr.
REQ-043 An access in flight during reset SHALL be abandoned with no response.
REQ-044 After reset release, the first grant SHALL be possible on the first rising edge.

Verification
REQ-045 Thread 0 reads 0x10210, c_miss=0, c_rd_data=0xDEADBEEF -> req_ready[0] at T, c_rd_en at T+1, rsp_valid[0] at T+3 with rdata 0xDEADBEEF and fault 0.
REQ-046 Threads 0..3 request simultaneously and hold their requests, rr_ptr=0 -> grants in the order 0,1,2,3,0; each thread waits for its own response before its next grant.
REQ-047 Thread 2 writes 0x10300 -> rsp_valid[2] at T+1 with rsp_fault=1; c_wr_en is never asserted.
REQ-048 Read with c_miss=1, then fill_done 5 cycles later, then c_miss=0 on replay -> fill_req high exactly 5 cycles with fill_addr equal to the request address; a second c_rd_en occurs; the response carries the replay data.
REQ-049 Miss with fill_done never asserted -> fill_req drops after 64 cycles; the response has rsp_fault=1 and rdata 0.
REQ-050 rst_n asserted while in FILL -> all outputs 0 immediately; no rsp_valid after release; the next grant goes to the lowest-index requester.
